// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Time-multiplexed seven-segment display controller. It shows a snapshot of
//   the core PC as hex on NUM_DIGITS digits and pages through PCs wider than
//   the display. It blinks the display while the core is halted and shows
//   sticky error flags while the core is in any other state.
//
//   Ports
//     clk_i         clock
//     rst_i         synchronous active-high reset
//     pc_i          value to display (DATA_WIDTH bits)
//     nstate_i      core state: 1 = NORMAL, 2 = HALT, anything else = error
//     interrupts_i  error flags, level or pulse, latched sticky
//     clr_err_i     one-cycle pulse that clears the sticky error latch
//     seg_o         active-low segments, bit7..bit0 = a,b,c,d,e,f,g,dp
//     an_o          active-low one-hot digit enable, bit k = digit k
//     page_o        current PC page
//
//   mode_q (snapshot of nstate_i, taken once per frame)
//     value   | meaning
//     --------+--------------------------------------------------
//     1       | NORMAL: paged hex display
//     2       | HALT:   paged hex display, blanked every other period
//     other   | error:  SEGERR on digit k when err_q[k], else blank

module seg_scan_display #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int PAGE_FRAMES  = 256,
    parameter int BLINK_FRAMES = 64,
    parameter int NUM_INTR     = 6,
    localparam int NUM_PAGES   = (DATA_WIDTH + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS),
    localparam int PAGE_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [2:0]            nstate_i,
    input  logic [NUM_INTR-1:0]   interrupts_i,
    input  logic                  clr_err_i,
    output logic [7:0]            seg_o,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic [PAGE_W-1:0]     page_o
);

    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int DIG_W  = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int FCNT_W = (PAGE_FRAMES > 1)  ? $clog2(PAGE_FRAMES)  : 1;
    localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(PAGE_FRAMES - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);

    localparam logic [2:0] MODE_NORMAL = 3'd1;
    localparam logic [2:0] MODE_HALT   = 3'd2;

    localparam logic [7:0] SEG_ERR   = 8'h6D;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [PRE_W-1:0]      pre_q;
    logic [DIG_W-1:0]      dig_q;
    logic [FCNT_W-1:0]     fcnt_q;
    logic [PAGE_W-1:0]     page_q;
    logic [BCNT_W-1:0]     bcnt_q;
    logic                  blink_q;
    logic [DATA_WIDTH-1:0] snap_q;
    logic [2:0]            mode_q;
    logic [NUM_INTR-1:0]   err_q;

    logic                  frame_end;
    logic                  new_run;
    logic                  cur_run;
    int                    nib_idx;
    logic [DATA_WIDTH-1:0] snap_shift;
    logic [NUM_INTR-1:0]   err_shift;
    logic [7:0]            seg_next;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h09;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            4'hF: s = 8'h71;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Frame boundary and the mode the counters see: the incoming nstate_i,
    // since mode_q is being reloaded on this very edge.
    always_comb begin
        frame_end = (pre_q == PRE_LAST) && (dig_q == DIG_LAST);
        new_run   = (nstate_i == MODE_NORMAL) || (nstate_i == MODE_HALT);
        cur_run   = (mode_q == MODE_NORMAL) || (mode_q == MODE_HALT);
    end

    // Rendering of the digit currently addressed by dig_q. Nibbles past the
    // top of the PC (last page of a non-multiple width) render blank.
    always_comb begin
        seg_next   = SEG_BLANK;
        nib_idx    = int'(page_q) * NUM_DIGITS + int'(dig_q);
        snap_shift = snap_q >> (nib_idx * 4);
        err_shift  = err_q >> dig_q;
        if (cur_run) begin
            if (!blink_q && (nib_idx * 4 < DATA_WIDTH)) begin
                seg_next = hex7(snap_shift[3:0]);
            end
        end else if ((int'(dig_q) < NUM_INTR) && err_shift[0]) begin
            seg_next = SEG_ERR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q   <= '0;
            dig_q   <= '0;
            fcnt_q  <= '0;
            page_q  <= '0;
            bcnt_q  <= '0;
            blink_q <= 1'b0;
            snap_q  <= '0;
            mode_q  <= MODE_NORMAL;
            err_q   <= '0;
            seg_o   <= SEG_BLANK;
            an_o    <= '1;
        end else begin
            // A flag raised together with the clear must survive it.
            err_q <= clr_err_i ? interrupts_i : (err_q | interrupts_i);

            if (pre_q == PRE_LAST) begin
                pre_q <= '0;
                dig_q <= (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end

            // Snapshot only at the frame boundary so a frame never tears.
            if (frame_end) begin
                snap_q <= pc_i;
                mode_q <= nstate_i;

                if (new_run) begin
                    if (fcnt_q == FCNT_LAST) begin
                        fcnt_q <= '0;
                        page_q <= (page_q == PAGE_LAST) ? '0 : page_q + PAGE_W'(1);
                    end else begin
                        fcnt_q <= fcnt_q + FCNT_W'(1);
                    end
                end

                if (nstate_i == MODE_HALT) begin
                    if (bcnt_q == BCNT_LAST) begin
                        bcnt_q  <= '0;
                        blink_q <= ~blink_q;
                    end else begin
                        bcnt_q <= bcnt_q + BCNT_W'(1);
                    end
                end else begin
                    bcnt_q  <= '0;
                    blink_q <= 1'b0;
                end
            end

            seg_o <= seg_next;
            an_o  <= ~(AN_ONE << dig_q);
        end
    end

    assign page_o = page_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display
//   Directed, table-driven bench for seg_scan_display with a 32-bit PC,
//   4 digits, 4 cycles per digit (16-cycle frame), 2 frames per page and
//   1 frame per blink half-period.

module tb_seg_scan_display;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic [2:0]  nstate_i;
    logic [5:0]  interrupts_i;
    logic        clr_err_i;
    logic [7:0]  seg_o;
    logic [3:0]  an_o;
    logic [0:0]  page_o;

    seg_scan_display #(
        .DATA_WIDTH  (32),
        .NUM_DIGITS  (4),
        .SCAN_DIV    (4),
        .PAGE_FRAMES (2),
        .BLINK_FRAMES(1),
        .NUM_INTR    (6)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pc_i        (pc_i),
        .nstate_i    (nstate_i),
        .interrupts_i(interrupts_i),
        .clr_err_i   (clr_err_i),
        .seg_o       (seg_o),
        .an_o        (an_o),
        .page_o      (page_o)
    );

    always #5 clk_i = ~clk_i;

    // One record per frame: inputs applied at the start of the frame, and the
    // digit patterns / page expected while that frame is on the display.
    // seg holds {digit3, digit2, digit1, digit0}.
    typedef struct {
        logic [31:0] pc;
        logic [2:0]  ns;
        logic [5:0]  intr;
        logic [31:0] seg;
        logic [0:0]  page;
    } frame_vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int pos   = 0;   // position within the frame of the next sampled output

    frame_vec_t vecs [10];
    logic [7:0] race_seg [16];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic step_check(input string nm, input logic [7:0] exp_seg);
        logic [3:0] exp_an;
        @(posedge clk_i);
        #1;
        exp_an = ~(4'b0001 << (pos / 4));
        check({nm, " seg"}, 32'(seg_o), 32'(exp_seg));
        check({nm, " an"}, 32'(an_o), 32'(exp_an));
        pos = (pos + 1) % 16;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h1234ABCD, 3'd1, 6'b000000, 32'h03030303, 1'b0};
        vecs[1] = '{32'h1234ABCD, 3'd1, 6'b000000, 32'h11C16385, 1'b0};
        vecs[2] = '{32'h1234ABCD, 3'd1, 6'b000000, 32'h9F250D99, 1'b1};
        vecs[3] = '{32'h1234ABCD, 3'd1, 6'b000000, 32'h9F250D99, 1'b1};
        vecs[4] = '{32'h1234ABCD, 3'd2, 6'b000000, 32'h11C16385, 1'b0};
        vecs[5] = '{32'h1234ABCD, 3'd2, 6'b000000, 32'hFFFFFFFF, 1'b0};
        vecs[6] = '{32'h1234ABCD, 3'd2, 6'b000000, 32'h9F250D99, 1'b1};
        vecs[7] = '{32'h1234ABCD, 3'd3, 6'b000101, 32'hFFFFFFFF, 1'b1};
        vecs[8] = '{32'h1234ABCD, 3'd3, 6'b000000, 32'hFF6DFF6D, 1'b1};
        vecs[9] = '{32'h1234ABCD, 3'd3, 6'b000000, 32'hFF6DFF6D, 1'b1};

        race_seg = '{8'hFF, 8'hFF, 8'h6D, 8'h6D,
                     8'hFF, 8'h6D, 8'h6D, 8'h6D,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF};

        rst_i        = 1'b1;
        pc_i         = '0;
        nstate_i     = 3'd1;
        interrupts_i = '0;
        clr_err_i    = 1'b0;

        @(posedge clk_i);
        #1;
        check("reset seg", 32'(seg_o), 32'hFF);
        check("reset an", 32'(an_o), 32'hF);
        check("reset page", 32'(page_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_i    = 1'b0;
        pc_i     = 32'h1234ABCD;
        nstate_i = 3'd1;
        pos      = 0;

        // Scan, paging, halt blink and error entry, one frame per record.
        for (int f = 0; f < 10; f++) begin
            for (int c = 0; c < 16; c++) begin
                step_check($sformatf("frame%0d c%0d", f, c), vecs[f].seg[8*(c/4) +: 8]);
                if (c == 0) begin
                    check($sformatf("frame%0d page", f), 32'(page_o), 32'(vecs[f].page));
                    pc_i         = vecs[f].pc;
                    nstate_i     = vecs[f].ns;
                    interrupts_i = vecs[f].intr;
                end
                if (c == 1) interrupts_i = '0;
            end
        end

        // Clear while digit 0 shows SEGERR: the clear edge still shows it,
        // everything after is blank.
        step_check("clr pre", 8'h6D);
        clr_err_i = 1'b1;
        step_check("clr edge", 8'h6D);
        clr_err_i = 1'b0;
        for (int c = 2; c < 16; c++) step_check($sformatf("clr blank c%0d", c), 8'hFF);

        // Set bits 0 and 2, then clear in the same cycle as bit 1 arrives.
        for (int c = 0; c < 16; c++) begin
            step_check($sformatf("race c%0d", c), race_seg[c]);
            if (c == 0) interrupts_i = 6'b000101;
            if (c == 1) interrupts_i = 6'b000000;
            if (c == 3) begin
                clr_err_i    = 1'b1;
                interrupts_i = 6'b000010;
            end
            if (c == 4) begin
                clr_err_i    = 1'b0;
                interrupts_i = 6'b000000;
            end
        end
        for (int c = 0; c < 16; c++) begin
            step_check($sformatf("race after c%0d", c), (c / 4 == 1) ? 8'h6D : 8'hFF);
            if (c == 0) check("race page held", 32'(page_o), 32'h1);
        end

        // Reset asserted while dig_q = 2.
        for (int c = 0; c < 9; c++) begin
            step_check($sformatf("pre-reset c%0d", c), (c / 4 == 1) ? 8'h6D : 8'hFF);
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("midreset seg", 32'(seg_o), 32'hFF);
        check("midreset an", 32'(an_o), 32'hF);
        check("midreset page", 32'(page_o), 32'h0);
        rst_i    = 1'b0;
        nstate_i = 3'd1;
        pc_i     = 32'h76543210;
        pos      = 0;
        for (int c = 0; c < 16; c++) step_check($sformatf("restart c%0d", c), 8'h03);
        for (int c = 0; c < 16; c++) begin
            logic [31:0] exp_row;
            exp_row = 32'h0D259F03;
            step_check($sformatf("restart pc c%0d", c), exp_row[8*(c/4) +: 8]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
